// File: rtl/cpu_prog_loader.sv
// Host-side program loader: pulls bytes from a valid/ready stream and pushes them into
// the 8-bit CPU over its pin-level load protocol (4-phase STROBE/ACK), then sets RUN.
module cpu_prog_loader #(
  parameter int SYNC_STAGES = 2,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] prog_len,
  input  logic       s_valid,
  input  logic [7:0] s_data,
  output logic       s_ready,
  output logic [7:0] pin_ui_in,
  output logic [7:0] pin_uio_in,
  input  logic [7:0] pin_uo_out,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] bytes_sent,
  output logic [2:0] dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_SETUP = 3'd2,
    S_STRB  = 3'd3,
    S_RELS  = 3'd4,
    S_FIN   = 3'd5,
    S_DONE  = 3'd6,
    S_ERROR = 3'd7
  } state_t;

  // Every output is a pure function of the state being entered, so it is
  // registered together with the state and never glitches.
  typedef struct packed {
    logic lm;
    logic strb;
    logic run;
    logic rdy;
    logic bsy;
    logic dn;
    logic er;
  } outs_t;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  function automatic outs_t decode(input state_t s);
    outs_t o;
    o = '0;
    case (s)
      S_FETCH: begin o.lm = 1'b1; o.rdy = 1'b1; o.bsy = 1'b1; end
      S_SETUP: begin o.lm = 1'b1; o.bsy = 1'b1; end
      S_STRB:  begin o.lm = 1'b1; o.strb = 1'b1; o.bsy = 1'b1; end
      S_RELS:  begin o.lm = 1'b1; o.bsy = 1'b1; end
      S_FIN:   begin o.bsy = 1'b1; end
      S_DONE:  begin o.run = 1'b1; o.dn = 1'b1; end
      S_ERROR: begin o.er = 1'b1; end
      default: ;
    endcase
    return o;
  endfunction

  state_t                 state;
  outs_t                  outs;
  logic [7:0]             len;
  logic [7:0]             tcnt;
  logic [SYNC_STAGES-1:0] ack_sync;
  logic                   ack_s;
  logic [7:0]             sent_inc;
  logic                   unused_pins;

  assign ack_s       = ack_sync[SYNC_STAGES-1];
  assign sent_inc    = bytes_sent + 8'd1;
  assign unused_pins = ^pin_uo_out[6:0];

  // ACK comes from the CPU clock domain; nothing looks at it before the last stage.
  always_ff @(posedge clk) begin
    if (rst) ack_sync <= '0;
    else     ack_sync <= {ack_sync[SYNC_STAGES-2:0], pin_uo_out[7]};
  end

  // Upstream stream: a byte moves on a clk edge where s_valid and s_ready are
  // both high; s_ready is high only while waiting for a byte, so at most one
  // byte is ever held (in pin_uio_in) and the source may hold s_valid freely.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      outs       <= '0;
      len        <= '0;
      tcnt       <= '0;
      bytes_sent <= '0;
      pin_uio_in <= '0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          if (start) begin
            len        <= prog_len;
            bytes_sent <= '0;
            if (prog_len != 8'd0) begin
              state <= S_FETCH;
              outs  <= decode(S_FETCH);
            end else begin
              state <= S_DONE;
              outs  <= decode(S_DONE);
            end
          end
        end
        S_FETCH: begin
          if (s_valid && outs.rdy) begin
            pin_uio_in <= s_data;
            state      <= S_SETUP;
            outs       <= decode(S_SETUP);
          end
        end
        S_SETUP: begin
          tcnt  <= '0;
          state <= S_STRB;
          outs  <= decode(S_STRB);
        end
        S_STRB: begin
          if (ack_s) begin
            tcnt  <= '0;
            state <= S_RELS;
            outs  <= decode(S_RELS);
          end else if (tcnt == TMO_LAST) begin
            pin_uio_in <= '0;
            state      <= S_ERROR;
            outs       <= decode(S_ERROR);
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_RELS: begin
          if (!ack_s) begin
            bytes_sent <= sent_inc;
            if (sent_inc == len) begin
              state <= S_FIN;
              outs  <= decode(S_FIN);
            end else begin
              state <= S_FETCH;
              outs  <= decode(S_FETCH);
            end
          end else if (tcnt == TMO_LAST) begin
            pin_uio_in <= '0;
            state      <= S_ERROR;
            outs       <= decode(S_ERROR);
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        S_FIN: begin
          pin_uio_in <= '0;
          state      <= S_DONE;
          outs       <= decode(S_DONE);
        end
        S_ERROR: ;
        default: begin
          state <= S_IDLE;
          outs  <= '0;
        end
      endcase
    end
  end

  assign pin_ui_in = {outs.lm, outs.strb, outs.run, 5'b00000};
  assign s_ready   = outs.rdy;
  assign busy      = outs.bsy;
  assign done      = outs.dn;
  assign error     = outs.er;
  assign dbg_state = state;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Bench for cpu_prog_loader: a behavioural CPU answers STROBE with ACK, a monitor
// captures the byte on every STROBE rise, and each test drains the scoreboard.
module tb_cpu_prog_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] prog_len;
  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;
  logic [7:0] pin_ui_in;
  logic [7:0] pin_uio_in;
  logic [7:0] pin_uo_out;
  logic       busy;
  logic       done;
  logic       error;
  logic [7:0] bytes_sent;
  logic [2:0] dbg_state;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] got_q[$];

  logic cpu_en    = 1'b1;
  logic force_ack = 1'b0;
  logic model_ack = 1'b0;
  logic strb_prev = 1'b0;
  int   hi_cnt    = 0;
  int   lo_cnt    = 0;

  always #5 clk = ~clk;

  assign pin_uo_out = {(cpu_en ? model_ack : force_ack), 7'h2a};

  cpu_prog_loader #(.SYNC_STAGES(2), .TIMEOUT_CYC(255)) dut (
    .clk(clk), .rst(rst), .start(start), .prog_len(prog_len),
    .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
    .pin_ui_in(pin_ui_in), .pin_uio_in(pin_uio_in), .pin_uo_out(pin_uo_out),
    .busy(busy), .done(done), .error(error), .bytes_sent(bytes_sent),
    .dbg_state(dbg_state)
  );

  // CPU model: ACK rises 2 cycles after STROBE rises, falls 2 cycles after it falls.
  always @(negedge clk) begin
    strb_prev <= pin_ui_in[6];
    if (pin_ui_in[6] && !strb_prev) got_q.push_back(pin_uio_in);
    if (pin_ui_in[6]) begin
      lo_cnt <= 0;
      hi_cnt <= hi_cnt + 1;
      if (hi_cnt + 1 >= 2) model_ack <= 1'b1;
    end else begin
      hi_cnt <= 0;
      lo_cnt <= lo_cnt + 1;
      if (lo_cnt + 1 >= 2) model_ack <= 1'b0;
    end
  end

  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00; prog_len = 8'h00;
    cpu_en = 1'b1; force_ack = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    exp_q.delete();
    got_q.delete();
  endtask

  task automatic do_start(input logic [7:0] len);
    prog_len = len;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    s_data = b;
    s_valid = 1'b1;
    while (!s_ready && n < 2000) begin @(negedge clk); n++; end
    total++;
    if (!s_ready) begin bad++; $display("FAIL send_wait byte=%h s_ready=%b exp=1", b, s_ready); end
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_sig(input string tag, input int which, input int max_cyc);
    int n = 0;
    logic v;
    v = (which == 0) ? done : (which == 1) ? s_ready : pin_ui_in[6];
    while (!v && n < max_cyc) begin
      @(negedge clk);
      n++;
      v = (which == 0) ? done : (which == 1) ? s_ready : pin_ui_in[6];
    end
    total++;
    if (!v) begin bad++; $display("FAIL %s_timeout act=0 exp=1 after %0d cycles", tag, n); end
  endtask

  task automatic drain_sb(input string tag);
    logic [7:0] e;
    logic [7:0] g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (got_q.size() == 0) begin
        bad++; $display("FAIL %s_byte act=none exp=%h", tag, e);
      end else begin
        g = got_q.pop_front();
        if (g !== e) begin bad++; $display("FAIL %s_byte act=%h exp=%h", tag, g, e); end
      end
    end
    total++;
    if (got_q.size() != 0) begin bad++; $display("FAIL %s_extra act=%0d exp=0", tag, got_q.size()); end
  endtask

  task automatic test_reset();
    apply_reset();
    total++;
    if ({pin_ui_in, pin_uio_in, bytes_sent, busy, done, error, s_ready} !== 28'h0) begin
      bad++; $display("FAIL reset_idle act=%h/%h/%h/%b%b%b%b exp=0", pin_ui_in, pin_uio_in,
                      bytes_sent, busy, done, error, s_ready);
    end
    do_start(8'd2);
    send_byte(8'h11);
    wait_sig("reset_refetch", 1, 100);
    cpu_en = 1'b0;
    send_byte(8'h22);
    wait_sig("reset_strb", 2, 20);
    total++;
    if (bytes_sent !== 8'd1) begin bad++; $display("FAIL reset_pre_cnt act=%0d exp=1", bytes_sent); end
    rst = 1'b1;
    @(negedge clk);
    total++;
    if (pin_ui_in !== 8'h00 || pin_uio_in !== 8'h00 || busy !== 1'b0 || bytes_sent !== 8'h00) begin
      bad++; $display("FAIL reset_mid act=ui%h uio%h busy%b cnt%h exp=0", pin_ui_in, pin_uio_in, busy, bytes_sent);
    end
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    total++;
    if (pin_ui_in !== 8'h00 || s_ready !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("FAIL reset_after act=ui%h rdy%b busy%b exp=0", pin_ui_in, s_ready, busy);
    end
  endtask

  task automatic test_load3();
    logic [7:0] pat [3] = '{8'hA5, 8'h3C, 8'hFF};
    apply_reset();
    do_start(8'd3);
    for (int i = 0; i < 3; i++) begin
      exp_q.push_back(pat[i]);
      send_byte(pat[i]);
    end
    wait_sig("load3_done", 0, 200);
    drain_sb("load3");
    total++;
    if (bytes_sent !== 8'd3) begin bad++; $display("FAIL load3_cnt act=%0d exp=3", bytes_sent); end
    total++;
    if (pin_ui_in !== 8'h20 || done !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("FAIL load3_run act=ui%h done%b busy%b exp=ui20 done1 busy0", pin_ui_in, done, busy);
    end
    total++;
    if (pin_uio_in !== 8'h00) begin bad++; $display("FAIL load3_uio act=%h exp=00", pin_uio_in); end
  endtask

  task automatic test_len0();
    int   first = 0;
    logic lm_seen = 1'b0;
    apply_reset();
    do_start(8'd0);
    for (int c = 1; c <= 4; c++) begin
      if (pin_ui_in[7]) lm_seen = 1'b1;
      if (done && first == 0) first = c;
      @(negedge clk);
    end
    total++;
    if (first < 1 || first > 2) begin bad++; $display("FAIL len0_latency act=%0d exp=1..2", first); end
    total++;
    if (lm_seen !== 1'b0) begin bad++; $display("FAIL len0_loadmode act=1 exp=0"); end
    total++;
    if (pin_ui_in !== 8'h20 || bytes_sent !== 8'd0) begin
      bad++; $display("FAIL len0_run act=ui%h cnt%0d exp=ui20 cnt0", pin_ui_in, bytes_sent);
    end
  endtask

  task automatic test_timeout();
    int n = 0;
    apply_reset();
    cpu_en = 1'b0;
    force_ack = 1'b0;
    do_start(8'd1);
    send_byte(8'h5A);
    wait_sig("tmo_strb", 2, 10);
    while (!error && n < 400) begin @(negedge clk); n++; end
    total++;
    if (n !== 255) begin bad++; $display("FAIL tmo_cycles act=%0d exp=255", n); end
    total++;
    if (pin_ui_in !== 8'h00 || pin_uio_in !== 8'h00 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL tmo_pins act=ui%h uio%h busy%b done%b exp=0", pin_ui_in, pin_uio_in, busy, done);
    end
    repeat (20) @(negedge clk);
    do_start(8'd1);
    repeat (3) @(negedge clk);
    total++;
    if (error !== 1'b1 || pin_ui_in !== 8'h00 || s_ready !== 1'b0) begin
      bad++; $display("FAIL tmo_sticky act=err%b ui%h rdy%b exp=err1 ui00 rdy0", error, pin_ui_in, s_ready);
    end
    apply_reset();
    total++;
    if (error !== 1'b0) begin bad++; $display("FAIL tmo_clear act=%b exp=0", error); end
  endtask

  task automatic test_gaps();
    logic [7:0] pat [4] = '{8'h01, 8'h80, 8'h7E, 8'hC3};
    logic       gap_ok;
    apply_reset();
    do_start(8'd4);
    for (int i = 0; i < 4; i++) begin
      exp_q.push_back(pat[i]);
      send_byte(pat[i]);
      if (i < 3) begin
        wait_sig("gap_fetch", 1, 100);
        gap_ok = 1'b1;
        for (int c = 0; c < 5; c++) begin
          if (pin_ui_in[6] !== 1'b0 || pin_ui_in[7] !== 1'b1) gap_ok = 1'b0;
          @(negedge clk);
        end
        total++;
        if (!gap_ok) begin bad++; $display("FAIL gap_pins act=ui%h exp=strobe0 lm1", pin_ui_in); end
        total++;
        if (bytes_sent !== 8'(i + 1)) begin
          bad++; $display("FAIL gap_cnt act=%0d exp=%0d", bytes_sent, i + 1);
        end
      end
    end
    wait_sig("gap_done", 0, 200);
    drain_sb("gap");
    total++;
    if (bytes_sent !== 8'd4) begin bad++; $display("FAIL gap_final act=%0d exp=4", bytes_sent); end
  endtask

  task automatic test_ack_high();
    apply_reset();
    cpu_en = 1'b0;
    force_ack = 1'b1;
    repeat (4) @(negedge clk);
    do_start(8'd2);
    exp_q.push_back(8'hB7);
    send_byte(8'hB7);
    repeat (15) @(negedge clk);
    do_start(8'd9);
    repeat (15) @(negedge clk);
    total++;
    if (bytes_sent !== 8'd0 || pin_ui_in !== 8'h80 || busy !== 1'b1) begin
      bad++; $display("FAIL ackhi_hold act=cnt%0d ui%h busy%b exp=cnt0 ui80 busy1", bytes_sent, pin_ui_in, busy);
    end
    force_ack = 1'b0;
    wait_sig("ackhi_fetch", 1, 20);
    total++;
    if (bytes_sent !== 8'd1) begin bad++; $display("FAIL ackhi_cnt act=%0d exp=1", bytes_sent); end
    cpu_en = 1'b1;
    exp_q.push_back(8'h48);
    send_byte(8'h48);
    wait_sig("ackhi_done", 0, 200);
    drain_sb("ackhi");
    total++;
    if (bytes_sent !== 8'd2 || done !== 1'b1) begin
      bad++; $display("FAIL ackhi_final act=cnt%0d done%b exp=cnt2 done1", bytes_sent, done);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_len = 8'h00; s_valid = 1'b0; s_data = 8'h00;
    test_reset();
    test_load3();
    test_len0();
    test_timeout();
    test_gaps();
    test_ack_high();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
